// File: rtl/md5_msg_window.sv
// Sliding byte window that turns a text stream into MD5-padded single-block
// candidates. Each accepted byte after the window fills produces one candidate.
module md5_msg_window #(
  parameter int STR_LEN = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clear,
  input  logic [7:0]   data_in,
  input  logic         data_valid,
  output logic         data_ready,
  output logic [447:0] m_out,
  output logic [63:0]  length_out,
  output logic         valid_out,
  output logic [31:0]  offset_out,
  output logic [5:0]   fill_count
);

  // MD5 stores the bit length little-endian in message byte order.
  function automatic logic [63:0] swap_bytes(input logic [63:0] v);
    logic [63:0] r;
    r = 64'h0;
    for (int b = 0; b < 8; b++) begin
      r[8*b +: 8] = v[56-8*b +: 8];
    end
    return r;
  endfunction

  localparam logic [63:0] BIT_LEN  = 64'(STR_LEN * 8);
  localparam logic [63:0] LEN_LE   = swap_bytes(BIT_LEN);
  localparam logic [5:0]  FILL_MAX = 6'(STR_LEN);

  logic [STR_LEN-1:0][7:0] win_r;
  logic [STR_LEN-1:0][7:0] win_next_s;
  logic [447:0]            m_r;
  logic [447:0]            m_next_s;
  logic [31:0]             byte_r;
  logic [31:0]             byte_next_s;
  logic [31:0]             offset_r;
  logic [5:0]              fill_r;
  logic [5:0]              fill_next_s;
  logic                    valid_r;
  logic                    accept_s;

  assign data_ready = en & ~clear & ~reset;
  assign accept_s   = en & data_valid & ~clear;
  assign length_out = LEN_LE;
  assign m_out      = m_r;
  assign valid_out  = valid_r;
  assign offset_out = offset_r;
  assign fill_count = fill_r;

  // Next window contents, counters and padded block for an accept cycle.
  always_comb begin
    win_next_s = win_r;
    for (int i = 0; i < STR_LEN - 1; i++) begin
      win_next_s[i] = win_r[i+1];
    end
    win_next_s[STR_LEN-1] = data_in;

    if (fill_r == FILL_MAX) begin
      fill_next_s = FILL_MAX;
    end else begin
      fill_next_s = fill_r + 6'd1;
    end

    byte_next_s = byte_r + 32'd1;

    m_next_s = 448'h0;
    for (int i = 0; i < STR_LEN; i++) begin
      m_next_s[447-8*i -: 8] = win_next_s[i];
    end
    m_next_s[447-8*STR_LEN -: 8] = 8'h80;
  end

  // Window, counters and candidate registers; reset beats clear beats en.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_r    <= '0;
      m_r      <= 448'h0;
      byte_r   <= 32'h0;
      offset_r <= 32'h0;
      fill_r   <= 6'd0;
      valid_r  <= 1'b0;
    end else if (clear) begin
      win_r    <= '0;
      byte_r   <= 32'h0;
      fill_r   <= 6'd0;
      valid_r  <= 1'b0;
    end else if (en) begin
      if (accept_s) begin
        win_r   <= win_next_s;
        fill_r  <= fill_next_s;
        byte_r  <= byte_next_s;
        valid_r <= (fill_next_s == FILL_MAX);
        if (fill_next_s == FILL_MAX) begin
          m_r      <= m_next_s;
          offset_r <= byte_next_s - 32'(STR_LEN);
        end
      end else begin
        valid_r <= 1'b0;
      end
    end
  end

  md5_msg_window_chk #(.STR_LEN(STR_LEN)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clear      (clear),
    .data_ready (data_ready),
    .valid_out  (valid_out),
    .fill_count (fill_count)
  );

endmodule

// Protocol invariants of the message window.
module md5_msg_window_chk #(
  parameter int STR_LEN = 19
) (
  input logic       clk,
  input logic       reset,
  input logic       en,
  input logic       clear,
  input logic       data_ready,
  input logic       valid_out,
  input logic [5:0] fill_count
);

  a_ready: assert property (@(posedge clk) data_ready == (en & ~clear & ~reset));
  a_valid_full: assert property (@(posedge clk) valid_out |-> (fill_count == 6'(STR_LEN)));
  a_fill_max: assert property (@(posedge clk) fill_count <= 6'(STR_LEN));
  a_reset: assert property (@(posedge clk) reset |=> (!valid_out && fill_count == 6'd0));
  a_clear: assert property (@(posedge clk) (clear && !reset) |=> (!valid_out && fill_count == 6'd0));

endmodule

// File: tb/tb_md5_msg_window.sv
// Directed bench for md5_msg_window: vector table for fill/slide/gap/stall,
// hand sequences for clear, reset, random gaps and the STR_LEN=1 build.
module tb_md5_msg_window;

  logic         clk = 1'b0;
  logic         reset, en, clear, data_valid, data_ready;
  logic [7:0]   data_in;
  logic [447:0] m_out;
  logic [63:0]  length_out;
  logic         valid_out;
  logic [31:0]  offset_out;
  logic [5:0]   fill_count;

  logic         reset1, en1, clear1, data_valid1, data_ready1;
  logic [7:0]   data_in1;
  logic [447:0] m_out1;
  logic [63:0]  length_out1;
  logic         valid_out1;
  logic [31:0]  offset_out1;
  logic [5:0]   fill_count1;

  always #5 clk = ~clk;

  md5_msg_window dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .m_out(m_out),
    .length_out(length_out), .valid_out(valid_out), .offset_out(offset_out),
    .fill_count(fill_count)
  );

  md5_msg_window #(.STR_LEN(1)) dut1 (
    .clk(clk), .reset(reset1), .en(en1), .clear(clear1), .data_in(data_in1),
    .data_valid(data_valid1), .data_ready(data_ready1), .m_out(m_out1),
    .length_out(length_out1), .valid_out(valid_out1), .offset_out(offset_out1),
    .fill_count(fill_count1)
  );

  typedef struct {
    logic         en, clr, dv;
    logic [7:0]   d;
    logic         exp_rdy, exp_valid;
    logic [5:0]   exp_fill;
    logic [31:0]  exp_off;
    logic [447:0] exp_m;
  } vec_t;

  vec_t         tbl[$];
  int           n_pass = 0;
  int           n_tot  = 0;
  logic [447:0] last_m;
  logic [31:0]  last_off;
  logic [447:0] cur_m;
  int           cands, got;

  localparam logic [63:0] LEN19 = 64'h9800_0000_0000_0000;
  localparam logic [63:0] LEN1  = 64'h0800_0000_0000_0000;

  task automatic chk(input string name, input logic [447:0] act, input logic [447:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [447:0] pack_msg(input string s);
    logic [447:0] m;
    m = 448'h0;
    for (int i = 0; i < s.len(); i++) m[447-8*i -: 8] = s[i];
    m[447-8*s.len() -: 8] = 8'h80;
    return m;
  endfunction

  task automatic add(input logic e, input logic c, input logic v, input logic [7:0] d,
                     input logic r, input logic ev, input logic [5:0] ef,
                     input logic [31:0] eo, input logic [447:0] em);
    vec_t t;
    t.en = e; t.clr = c; t.dv = v; t.d = d; t.exp_rdy = r; t.exp_valid = ev;
    t.exp_fill = ef; t.exp_off = eo; t.exp_m = em;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic e, input logic c, input logic r, input logic v,
                       input logic [7:0] d);
    @(negedge clk);
    en = e; clear = c; reset = r; data_valid = v; data_in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds a string (optionally with random data_valid gaps), counting candidates.
  task automatic feed(input string s, input bit gaps);
    int cyc;
    logic v;
    cyc = 0; got = 0; cands = 0;
    while (got < s.len() && cyc < 40 * s.len()) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive(1'b1, 1'b0, 1'b0, v, v ? s[got] : 8'hEE);
      tick();
      if (valid_out) begin
        cands++;
        last_m = m_out;
        last_off = offset_out;
      end
      if (v) got++;
      cyc++;
    end
  endtask

  initial begin
    string s0;
    s0 = "abcdefghijklmnopqrs";
    reset = 1'b1; en = 1'b1; clear = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    reset1 = 1'b1; en1 = 1'b1; clear1 = 1'b0; data_valid1 = 1'b0; data_in1 = 8'h00;
    #1;
    chk("reset_ready", 448'(data_ready), 448'd0);
    tick(); tick();
    chk("reset_valid", 448'(valid_out), 448'd0);
    chk("reset_fill", 448'(fill_count), 448'd0);
    chk("reset_m", m_out, 448'h0);
    chk("reset_off", 448'(offset_out), 448'd0);
    chk("reset_len", 448'(length_out), 448'(LEN19));

    cur_m = 448'h0;
    for (int i = 0; i < 19; i++) begin
      if (i == 18) cur_m = pack_msg(s0);
      add(1'b1, 1'b0, 1'b1, s0[i], 1'b1, (i == 18), 6'(i + 1), 32'd0, cur_m);
    end
    cur_m = pack_msg("bcdefghijklmnopqrst");
    add(1'b1, 1'b0, 1'b1, "t", 1'b1, 1'b1, 6'd19, 32'd1, cur_m);
    cur_m = pack_msg("cdefghijklmnopqrstu");
    add(1'b1, 1'b0, 1'b1, "u", 1'b1, 1'b1, 6'd19, 32'd2, cur_m);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'd19, 32'd2, cur_m);
    cur_m = pack_msg("defghijklmnopqrstuv");
    add(1'b1, 1'b0, 1'b1, "v", 1'b1, 1'b1, 6'd19, 32'd3, cur_m);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, 1'b1, "w", 1'b0, 1'b1, 6'd19, 32'd3, cur_m);
    cur_m = pack_msg("efghijklmnopqrstuvw");
    add(1'b1, 1'b0, 1'b1, "w", 1'b1, 1'b1, 6'd19, 32'd4, cur_m);

    foreach (tbl[k]) begin
      drive(tbl[k].en, tbl[k].clr, 1'b0, tbl[k].dv, tbl[k].d);
      #1;
      chk($sformatf("vec%0d_ready", k), 448'(data_ready), 448'(tbl[k].exp_rdy));
      tick();
      chk($sformatf("vec%0d_valid", k), 448'(valid_out), 448'(tbl[k].exp_valid));
      chk($sformatf("vec%0d_fill", k), 448'(fill_count), 448'(tbl[k].exp_fill));
      chk($sformatf("vec%0d_off", k), 448'(offset_out), 448'(tbl[k].exp_off));
      chk($sformatf("vec%0d_m", k), m_out, tbl[k].exp_m);
    end
    chk("slide_len", 448'(length_out), 448'(LEN19));

    // Clear mid-stream, then clear again (with en low) after 10 bytes.
    drive(1'b1, 1'b1, 1'b0, 1'b1, "z");
    #1;
    chk("clear_ready", 448'(data_ready), 448'd0);
    tick();
    chk("clear_valid", 448'(valid_out), 448'd0);
    chk("clear_fill", 448'(fill_count), 448'd0);
    feed("klmnopqrst", 1'b0);
    chk("part_cands", 448'(cands), 448'd0);
    chk("part_fill", 448'(fill_count), 448'd10);
    drive(1'b0, 1'b1, 1'b0, 1'b1, "?");
    tick();
    chk("clear2_fill", 448'(fill_count), 448'd0);
    chk("clear2_valid", 448'(valid_out), 448'd0);
    feed("0123456789ABCDEFGHI", 1'b0);
    chk("clr_cands", 448'(cands), 448'd1);
    chk("clr_m", last_m, pack_msg("0123456789ABCDEFGHI"));
    chk("clr_off", 448'(last_off), 448'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("idle_valid", 448'(valid_out), 448'd0);

    // Reset mid-fill with a byte presented, then refill with random gaps.
    feed("abcde", 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, "Q");
    #1;
    chk("rst_ready", 448'(data_ready), 448'd0);
    tick();
    chk("rst_valid", 448'(valid_out), 448'd0);
    chk("rst_fill", 448'(fill_count), 448'd0);
    chk("rst_m", m_out, 448'h0);
    chk("rst_off", 448'(offset_out), 448'd0);
    chk("rst_len", 448'(length_out), 448'(LEN19));
    feed(s0, 1'b1);
    chk("gap_got", 448'(got), 448'd19);
    chk("gap_cands", 448'(cands), 448'd1);
    chk("gap_m", last_m, pack_msg(s0));
    chk("gap_off", 448'(last_off), 448'd0);
    chk("gap_fill", 448'(fill_count), 448'd19);

    // STR_LEN=1 build.
    @(negedge clk);
    reset1 = 1'b0; en1 = 1'b1; data_valid1 = 1'b1; data_in1 = "x";
    tick();
    chk("l1_valid", 448'(valid_out1), 448'd1);
    chk("l1_m", m_out1, {16'h7880, 432'h0});
    chk("l1_len", 448'(length_out1), 448'(LEN1));
    chk("l1_off", 448'(offset_out1), 448'd0);
    chk("l1_fill", 448'(fill_count1), 448'd1);
    @(negedge clk);
    data_in1 = "y";
    tick();
    chk("l1_off2", 448'(offset_out1), 448'd1);
    chk("l1_m2", m_out1, {16'h7980, 432'h0});

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/md5_msg_window.md
MD5_MSG_WINDOW -- requirements
Module: md5_msg_window

Interface
REQ-001 Parameter: STR_LEN, default 19, string length in bytes; legal range 1..55.
REQ-002 Port: clk  input  1  clock; all logic is clocked on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: en  input  1  global pipeline enable, shared with the hash core.
REQ-005 Port: clear  input  1  synchronous window flush at the start of a new text.
REQ-006 Port: data_in  input  8  text byte.
REQ-007 Port: data_valid  input  1  data_in is present this cycle.
REQ-008 Port: data_ready  output  1  byte accepted when data_valid and data_ready are both 1.
REQ-009 Port: m_out  output  448  padded message block; feeds the hash core message input.
REQ-010 Port: length_out  output  64  message bit length; feeds the hash core length input.
REQ-011 Port: valid_out  output  1  m_out, length_out and offset_out hold a new candidate.
REQ-012 Port: offset_out  output  32  byte offset, since the last clear, of the candidate's first byte.
REQ-013 Port: fill_count  output  6  bytes currently in the window, saturating at STR_LEN.

Function
REQ-014 data_ready SHALL equal en & ~clear & ~reset, combinationally.
REQ-015 When en=0 and clear=0, every register SHALL hold its value.
REQ-016 Accept cycle: the window SHALL shift by one byte, with the oldest byte dropped and data_in entering as the newest byte.
REQ-017 Accept cycle: fill_count SHALL increment, saturating at STR_LEN.
REQ-018 Accept cycle: byte_count (internal, 32 bits) SHALL increment, wrapping modulo 2^32.
REQ-019 Window layout: window byte i (0 = oldest) SHALL appear at m_out[447-8i -: 8], for i = 0..STR_LEN-1.
REQ-020 Padding: m_out byte STR_LEN SHALL be 8'h80, and all remaining m_out bytes SHALL be 8'h00.
REQ-021 length_out SHALL be the constant STR_LEN*8, stored least-significant byte first in message byte order: length_out[63:56] is the LSB.
REQ-022 For STR_LEN=19, length_out SHALL be 64'h9800_0000_0000_0000.
REQ-023 valid_out SHALL be registered and SHALL be 1 for exactly one en=1 cycle, namely the cycle after an accept cycle in which fill_count reaches or remains STR_LEN.
REQ-024 In every other cycle with en=1, valid_out SHALL be 0, including when data_valid=0 or the window is not yet full.
REQ-025 offset_out SHALL be registered together with valid_out and SHALL equal byte_count - STR_LEN (modulo 2^32) after the accepted byte is counted.
REQ-026 Latency: one clk from accept to valid_out, with en held at 1.
REQ-027 Gaps in data_valid SHALL produce no candidates and SHALL leave the window unchanged.
REQ-028 clear=1 (regardless of en) SHALL zero the window, fill_count, byte_count and valid_out on that edge, and SHALL accept no byte that cycle.
REQ-029 A subsequent candidate after clear SHALL require STR_LEN newly accepted bytes.
REQ-030 m_out and offset_out SHALL hold their last values when valid_out=0; m_out may be zero immediately after clear or reset.

Reset
REQ-031 On reset=1 at a clock edge, the window SHALL be all zero.
REQ-032 On reset=1 at a clock edge, m_out SHALL be 0, length_out SHALL remain the constant, valid_out SHALL be 0, offset_out SHALL be 0, fill_count SHALL be 0 and byte_count SHALL be 0.
REQ-033 Reset SHALL take priority over clear, en and data_valid.
REQ-034 Reset asserted mid-fill SHALL discard all partial window contents.

Verification
REQ-035 Fill scenario: with en=1, feed "abcdefghijklmnopqrs" (19 bytes) on consecutive cycles, so fill_count ends at 19. After the 19th byte, valid_out=1 for one cycle with m_out[447:296] = the ASCII string, m_out[295:288] = 8'h80, m_out[287:0] = 0, length_out = 64'h9800_0000_0000_0000 and offset_out = 0. No valid_out SHALL occur before the 19th byte.
REQ-036 Slide scenario: continue the fill scenario with "t" then "u". Two consecutive candidates result: "bcdefghijklmnopqrst" with offset 1, then "cdefghijklmnopqrstu" with offset 2.
REQ-037 Stall scenario: drop en to 0 for 5 cycles while data_valid=1. data_ready=0, and all outputs, including valid_out=1 if it was set, hold unchanged. The stream resumes with no byte lost or duplicated.
REQ-038 Clear scenario: assert clear after 10 bytes, then feed 19 bytes "0123456789ABCDEFGHI". fill_count=0 after clear. Exactly one candidate results, with offset_out = 0 and the new string.
REQ-039 Reset scenario: assert reset for 1 cycle during the fill scenario with en=1 and data_valid=1. All outputs go to their reset values, and the byte presented with reset is not accepted.
REQ-040 Gap/parameter scenario: feed 19 bytes with random data_valid gaps, which must yield exactly one candidate. Rebuild with STR_LEN=1 and feed "x": m_out[447:432] = 16'h7880 and length_out = 64'h0800_0000_0000_0000.
